zero_test_sequencer: RTL



---
 rtl/zero_test_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/zero_test_sequencer.sv
// Run sequencer for the zero instruction engine: clears the engine, single-steps it
// under a step budget, then compares the out channel against an expected-value ROM.
module zero_test_sequencer #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 2000,
  parameter int OutAddrWidth       = 11,
  parameter int NExpected          = 3,
  parameter int MaxSteps           = 7,
  parameter int StepsWidth         = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  output logic                          engineReset,
  output logic                          step,
  input  logic                          halted,
  input  logic [OutAddrWidth-1:0]       outMemPos,
  output logic [OutAddrWidth-1:0]       rdAddr,
  input  logic [MemoryElementWidth-1:0] rdData,
  output logic [OutAddrWidth-1:0]       expAddr,
  input  logic [MemoryElementWidth-1:0] expData,
  output logic [StepsWidth-1:0]         steps,
  output logic                          finished,
  output logic                          success,
  output logic                          timeout,
  output logic [OutAddrWidth-1:0]       failIndex
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [OutAddrWidth-1:0] N_EXP     = OutAddrWidth'(NExpected);
  localparam logic [OutAddrWidth-1:0] LAST_IDX  = OutAddrWidth'((NExpected > 0) ? NExpected - 1 : 0);
  localparam logic [OutAddrWidth-1:0] ADDR_ONE  = OutAddrWidth'(1);
  localparam logic [StepsWidth-1:0]   MAX_STEPS = StepsWidth'(MaxSteps);

  // state_q is the FSM observation point for checkers bound to this block.
  state_e                      state_q;
  logic                        run_q;
  logic                        eng_rst_q;
  logic                        first_q;
  logic [OutAddrWidth-1:0]     rd_addr_q;
  logic [OutAddrWidth-1:0]     cmp_idx_q;
  logic [OutAddrWidth-1:0]     fail_idx_q;
  logic [StepsWidth-1:0]       steps_q;
  logic                        finished_q;
  logic                        success_q;
  logic                        timeout_q;

  logic run_edge;
  logic count_ok;
  logic at_budget;
  logic data_match;

  assign run_edge   = run & ~run_q;
  assign count_ok   = (outMemPos == N_EXP);
  assign at_budget  = (steps_q == MAX_STEPS);
  assign data_match = (rdData == expData);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      eng_rst_q  <= 1'b0;
      first_q    <= 1'b0;
      rd_addr_q  <= '0;
      cmp_idx_q  <= '0;
      fail_idx_q <= '0;
      steps_q    <= '0;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      run_q     <= run;
      eng_rst_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (run_edge) begin
            state_q    <= S_CLEAR;
            eng_rst_q  <= 1'b1;
            finished_q <= 1'b0;
            success_q  <= 1'b0;
            timeout_q  <= 1'b0;
            steps_q    <= '0;
            fail_idx_q <= '0;
          end
        end
        S_CLEAR: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (halted) begin
            state_q <= S_CHECK;
            first_q <= 1'b1;
          end else if (at_budget) begin
            state_q    <= S_DONE;
            timeout_q  <= 1'b1;
            success_q  <= 1'b0;
            finished_q <= 1'b1;
          end else begin
            steps_q <= steps_q + 1'b1;
          end
        end
        S_CHECK: begin
          first_q <= 1'b0;
          if (first_q) begin
            // Entry cycle: count check, and address 0 is already on rdAddr.
            if (!count_ok) begin
              state_q    <= S_DONE;
              fail_idx_q <= N_EXP;
              success_q  <= 1'b0;
              finished_q <= 1'b1;
            end else if (NExpected == 0) begin
              state_q    <= S_DONE;
              success_q  <= 1'b1;
              finished_q <= 1'b1;
            end else begin
              cmp_idx_q <= '0;
              rd_addr_q <= (LAST_IDX != '0) ? ADDR_ONE : '0;
            end
          end else if (!data_match) begin
            state_q    <= S_DONE;
            fail_idx_q <= cmp_idx_q;
            success_q  <= 1'b0;
            finished_q <= 1'b1;
          end else if (cmp_idx_q == LAST_IDX) begin
            state_q    <= S_DONE;
            success_q  <= 1'b1;
            finished_q <= 1'b1;
          end else begin
            cmp_idx_q <= cmp_idx_q + 1'b1;
            if (rd_addr_q != LAST_IDX) begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Step is decided from the live halted level so no instruction ever issues
  // in a cycle that observes the halt; reset kills both strobes immediately.
  assign step        = (state_q == S_RUN) & ~halted & ~at_budget & ~reset;
  assign engineReset = eng_rst_q & ~reset;

  assign rdAddr    = (state_q == S_CHECK && first_q && count_ok) ? '0 : rd_addr_q;
  assign expAddr   = rdAddr;
  assign steps     = steps_q;
  assign finished  = finished_q;
  assign success   = success_q;
  assign timeout   = timeout_q;
  assign failIndex = fail_idx_q;

  a_no_step_on_halt: assert property (@(posedge clock) disable iff (reset) !(step && halted));
  a_steps_bounded:   assert property (@(posedge clock) steps_q <= MAX_STEPS);
  a_strobes_apart:   assert property (@(posedge clock) !(step && engineReset));
  a_rd_addr_range:   assert property (@(posedge clock) int'(rdAddr) < NOut);

endmodule
